// File: rtl/updn_cnt_pkg.sv
// rtl/updn_cnt_pkg.sv - shared constants for the up/down modulo counter
//
// Purpose: mode encodings and the default counter width used by
//          updn_mod_counter and anything that drives its mode input.
package updn_cnt_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/updn_mod_counter.sv
// rtl/updn_mod_counter.sv - up/down modulo counter with wrap/saturate modes
//
// Purpose: WIDTH-bit counter over 0..MAX with a per-cycle step, wrap or
//          saturate behaviour, parallel load and a terminal-count pulse.
// Macro:   UPDN_CNT_OVF_STICKY_EN enables the sticky overflow flag; without
//          it ovf_sticky reads 0 and ovf_clr is ignored.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         count enable
//   updown     1 = up, 0 = down
//   step       magnitude added/subtracted per enabled cycle
//   mode       0 = wrap modulo MAX+1, 1 = saturate at 0/MAX
//   load       parallel load strobe (beats en)
//   load_val   value to load, clamped to MAX
//   ovf_clr    clears ovf_sticky
//   count      registered count
//   at_max     count == MAX
//   at_min     count == 0
//   tc         one-cycle pulse after an update that wrapped or clamped
//   ovf_sticky sticky record of any wrap/clamp
module updn_mod_counter
  import updn_cnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MAX   = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             updown,
  input  logic [WIDTH-1:0] step,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             tc,
  output logic             ovf_sticky
);

  // Arithmetic runs one bit wider so count+step and count+MOD never truncate;
  // the modulus itself needs that extra bit when MAX = 2**WIDTH-1.
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MAX + 1);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  // Returns {event, next_count}; event marks a wrap or clamp.
  function automatic logic [WIDTH:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] stp,
    input logic             up,
    input logic             md
  );
    logic [WIDTH:0] c;
    logic [WIDTH:0] s;
    logic [WIDTH:0] r;
    logic           evt;
    c   = {1'b0, cur};
    evt = 1'b0;
    // Oversized steps: reduced modulo in wrap mode, clamped in saturate mode.
    if (cnt_mode_e'(md) == MODE_WRAP) begin
      s = {1'b0, stp} % MOD_W;
    end else begin
      s = ({1'b0, stp} > MAX_W) ? MAX_W : {1'b0, stp};
    end
    if (up) begin
      r = c + s;
      if (r > MAX_W) begin
        evt = 1'b1;
        r   = (cnt_mode_e'(md) == MODE_WRAP) ? (r - MOD_W) : MAX_W;
      end
    end else begin
      if (s > c) begin
        evt = 1'b1;
        r   = (cnt_mode_e'(md) == MODE_WRAP) ? (c + MOD_W - s) : '0;
      end else begin
        r = c - s;
      end
    end
    return {evt, r[WIDTH-1:0]};
  endfunction

  logic [WIDTH:0]   nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             tc_d;

  always_comb begin
    nxt          = next_count(count, step, updown, mode);
    load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
    // Only an enabled, non-load, non-reset edge can produce an event.
    tc_d         = rst_n & ~load & en & nxt[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_clamped;
    end else if (en) begin
      count <= nxt[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    tc <= tc_d;
  end

`ifdef UPDN_CNT_OVF_STICKY_EN
  // Set follows the same edge that raises tc, so a set coincident with a
  // clear leaves the flag high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (tc_d) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

  assign at_max = (count == MAX_C);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_updn_mod_counter.sv
// tb/tb_updn_mod_counter.sv - self-checking bench for updn_mod_counter
module tb_updn_mod_counter;

  localparam int WIDTH = 4;
  localparam int MAX   = 9;
`ifdef UPDN_CNT_OVF_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, en, updown, mode, load, ovf_clr;
  logic [WIDTH-1:0] step, load_val, count;
  logic             at_max, at_min, tc, ovf_sticky;

  always #5 clk = ~clk;

  updn_mod_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .updown(updown), .step(step),
    .mode(mode), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .count(count), .at_max(at_max), .at_min(at_min), .tc(tc),
    .ovf_sticky(ovf_sticky)
  );

  typedef struct {
    int r, e, u, s, m, l, lv, clr;
    int xc, xtc, xov;
  } vec_t;

  typedef struct {
    int c, tc, ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input int r, e, u, s, m, l, lv, clr);
    rst_n    = (r != 0);
    en       = (e != 0);
    updown   = (u != 0);
    step     = WIDTH'(s);
    mode     = (m != 0);
    load     = (l != 0);
    load_val = WIDTH'(lv);
    ovf_clr  = (clr != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t x;
    x.c  = v.xc;
    x.tc = v.xtc;
    x.ov = (STICKY && v.xov != 0) ? 1 : 0;
    exp_q.push_back(x);
    drive(v.r, v.e, v.u, v.s, v.m, v.l, v.lv, v.clr);
  endtask

  task automatic test_reset();
    vec_t tab [2];
    exp_t x;
    tab = '{'{0,1,1,1,0,1,5,0, 0,0,0}, '{0,1,1,1,0,1,5,0, 0,0,0}};
    foreach (tab[i]) begin
      apply_vec(tab[i]);
      x = exp_q.pop_front();
      checks++;
      if ({count, tc, ovf_sticky, at_max, at_min} !==
          {4'(x.c), x.tc != 0, x.ov != 0, x.c == MAX, x.c == 0}) begin
        errors++;
        $display("FAIL reset[%0d]: count=%0d tc=%b ovf=%b max=%b min=%b, expected count=%0d tc=%0d ovf=%0d",
                 i, count, tc, ovf_sticky, at_max, at_min, x.c, x.tc, x.ov);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t tab [10];
    exp_t x;
    tab = '{'{1,0,1,0,0,1,0,1, 0,0,0},
            '{1,1,1,3,0,0,0,0, 3,0,0},
            '{1,1,1,3,0,0,0,0, 6,0,0},
            '{1,1,1,3,0,0,0,0, 9,0,0},
            '{1,1,1,3,0,0,0,0, 2,1,1},
            '{1,1,0,3,0,0,0,0, 9,1,1},
            '{1,1,1,15,0,0,0,0, 4,1,1},
            '{1,1,0,12,0,0,0,0, 2,0,1},
            '{1,1,1,0,0,0,0,0, 2,0,1},
            '{1,0,1,5,0,0,0,0, 2,0,1}};
    foreach (tab[i]) begin
      apply_vec(tab[i]);
      x = exp_q.pop_front();
      checks++;
      if ({count, tc, ovf_sticky, at_max, at_min} !==
          {4'(x.c), x.tc != 0, x.ov != 0, x.c == MAX, x.c == 0}) begin
        errors++;
        $display("FAIL wrap[%0d]: count=%0d tc=%b ovf=%b max=%b min=%b, expected count=%0d tc=%0d ovf=%0d",
                 i, count, tc, ovf_sticky, at_max, at_min, x.c, x.tc, x.ov);
      end
    end
  endtask

  task automatic test_saturate();
    vec_t tab [10];
    exp_t x;
    tab = '{'{1,0,1,0,1,1,7,1, 7,0,0},
            '{1,1,1,4,1,0,0,0, 9,1,1},
            '{1,1,1,4,1,0,0,0, 9,1,1},
            '{1,0,1,0,1,1,1,0, 1,0,1},
            '{1,1,0,4,1,0,0,0, 0,1,1},
            '{1,0,1,0,1,1,5,0, 5,0,1},
            '{1,1,1,4,1,0,0,0, 9,0,1},
            '{1,0,1,0,1,1,4,0, 4,0,1},
            '{1,1,0,4,1,0,0,0, 0,0,1},
            '{1,1,1,15,1,0,0,0, 9,0,1}};
    foreach (tab[i]) begin
      apply_vec(tab[i]);
      x = exp_q.pop_front();
      checks++;
      if ({count, tc, ovf_sticky, at_max, at_min} !==
          {4'(x.c), x.tc != 0, x.ov != 0, x.c == MAX, x.c == 0}) begin
        errors++;
        $display("FAIL saturate[%0d]: count=%0d tc=%b ovf=%b max=%b min=%b, expected count=%0d tc=%0d ovf=%0d",
                 i, count, tc, ovf_sticky, at_max, at_min, x.c, x.tc, x.ov);
      end
    end
  endtask

  task automatic test_load();
    vec_t tab [4];
    exp_t x;
    tab = '{'{1,0,1,0,0,1,3,1, 3,0,0},
            '{1,1,1,1,0,1,13,0, 9,0,0},
            '{1,0,1,1,0,0,0,0, 9,0,0},
            '{1,1,1,1,0,1,9,0, 9,0,0}};
    foreach (tab[i]) begin
      apply_vec(tab[i]);
      x = exp_q.pop_front();
      checks++;
      if ({count, tc, ovf_sticky, at_max, at_min} !==
          {4'(x.c), x.tc != 0, x.ov != 0, x.c == MAX, x.c == 0}) begin
        errors++;
        $display("FAIL load[%0d]: count=%0d tc=%b ovf=%b max=%b min=%b, expected count=%0d tc=%0d ovf=%0d",
                 i, count, tc, ovf_sticky, at_max, at_min, x.c, x.tc, x.ov);
      end
    end
  endtask

  task automatic test_sticky();
    vec_t tab [8];
    exp_t x;
    tab = '{'{1,0,1,0,0,1,8,1, 8,0,0},
            '{1,1,1,3,0,0,0,0, 1,1,1},
            '{1,0,1,0,0,0,0,0, 1,0,1},
            '{1,0,1,0,0,0,0,0, 1,0,1},
            '{1,0,1,0,0,0,0,0, 1,0,1},
            '{1,1,1,9,0,0,0,1, 0,1,1},
            '{1,0,1,0,0,0,0,1, 0,0,0},
            '{1,0,1,0,0,0,0,0, 0,0,0}};
    foreach (tab[i]) begin
      apply_vec(tab[i]);
      x = exp_q.pop_front();
      checks++;
      if ({count, tc, ovf_sticky, at_max, at_min} !==
          {4'(x.c), x.tc != 0, x.ov != 0, x.c == MAX, x.c == 0}) begin
        errors++;
        $display("FAIL sticky[%0d]: count=%0d tc=%b ovf=%b max=%b min=%b, expected count=%0d tc=%0d ovf=%0d",
                 i, count, tc, ovf_sticky, at_max, at_min, x.c, x.tc, x.ov);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t tab [7];
    exp_t x;
    tab = '{'{1,0,1,0,0,1,8,1, 8,0,0},
            '{1,1,1,3,0,0,0,0, 1,1,1},
            '{1,0,1,0,0,1,6,0, 6,0,1},
            '{0,1,1,1,0,1,5,0, 0,0,0},
            '{1,1,1,1,0,0,0,0, 1,0,0},
            '{1,1,1,1,0,0,0,0, 2,0,0},
            '{1,1,1,1,0,0,0,0, 3,0,0}};
    foreach (tab[i]) begin
      apply_vec(tab[i]);
      x = exp_q.pop_front();
      checks++;
      if ({count, tc, ovf_sticky, at_max, at_min} !==
          {4'(x.c), x.tc != 0, x.ov != 0, x.c == MAX, x.c == 0}) begin
        errors++;
        $display("FAIL reset_mid[%0d]: count=%0d tc=%b ovf=%b max=%b min=%b, expected count=%0d tc=%0d ovf=%0d",
                 i, count, tc, ovf_sticky, at_max, at_min, x.c, x.tc, x.ov);
      end
    end
  endtask

  // Random traffic against an integer reference model of the counter.
  task automatic test_random();
    int   mc, mov, mt, s, t, r, e, u, m, l, lv, clr;
    exp_t x;
    mc  = 0;
    mov = 0;
    for (int i = 0; i < 300; i++) begin
      r   = (i == 0 || $urandom_range(0, 99) < 3) ? 0 : 1;
      e   = ($urandom_range(0, 99) < 80) ? 1 : 0;
      u   = int'($urandom_range(0, 1));
      s   = int'($urandom_range(0, 15));
      m   = int'($urandom_range(0, 1));
      l   = ($urandom_range(0, 99) < 10) ? 1 : 0;
      lv  = int'($urandom_range(0, 15));
      clr = ($urandom_range(0, 99) < 20) ? 1 : 0;
      mt  = 0;
      if (r == 0) begin
        mc  = 0;
        mov = 0;
      end else if (l != 0) begin
        mc = (lv > MAX) ? MAX : lv;
      end else if (e != 0) begin
        if (m == 0) begin
          t = (u != 0) ? mc + (s % (MAX + 1)) : mc - (s % (MAX + 1));
          if (t > MAX) begin t = t - (MAX + 1); mt = 1; end
          if (t < 0)   begin t = t + (MAX + 1); mt = 1; end
        end else begin
          t = (s > MAX) ? MAX : s;
          t = (u != 0) ? mc + t : mc - t;
          if (t > MAX) begin t = MAX; mt = 1; end
          if (t < 0)   begin t = 0;   mt = 1; end
        end
        mc = t;
      end
      if (r != 0 && STICKY) begin
        if (mt != 0) mov = 1;
        else if (clr != 0) mov = 0;
      end
      x.c  = mc;
      x.tc = mt;
      x.ov = mov;
      exp_q.push_back(x);
      drive(r, e, u, s, m, l, lv, clr);
      x = exp_q.pop_front();
      checks++;
      if ({count, tc, ovf_sticky, at_max, at_min} !==
          {4'(x.c), x.tc != 0, x.ov != 0, x.c == MAX, x.c == 0}) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d tc=%b ovf=%b max=%b min=%b, expected count=%0d tc=%0d ovf=%0d",
                 i, count, tc, ovf_sticky, at_max, at_min, x.c, x.tc, x.ov);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    updown   = 1'b1;
    step     = '0;
    mode     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    ovf_clr  = 1'b0;
    test_reset();
    test_wrap();
    test_saturate();
    test_load();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
